// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the fetch / load-store memory port arbiter.
// Contents:
//   MEM_ADDR_WIDTH, REG_DATA_WIDTH : default address and data widths
//   ARB_TIMEOUT_DEFAULT            : default wait-state abort limit in cycles
//   owner_e                        : which requester owns the bus transaction
//   arb_state_e                    : arbiter FSM states
//   FETCH_BE                       : byte enables used for every instruction fetch
package mem_port_arbiter_pkg;

  localparam int MEM_ADDR_WIDTH      = 32;
  localparam int REG_DATA_WIDTH      = 32;
  localparam int ARB_TIMEOUT_DEFAULT = 16;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_WAIT_GNT  = 2'd1,
    ARB_WAIT_RESP = 2'd2
  } arb_state_e;

  localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2
// Two-requester round-robin picker, purely combinational.
// Ports:
//   reqs       in  [1:0] : bit 0 = fetch request, bit 1 = data request
//   last_owner in        : requester that received the most recent grant
//   winner     out       : requester to serve next (meaningful only when reqs != 0)
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] reqs,
  input  owner_e     last_owner,
  output owner_e     winner
);

  // On a conflict the requester that did not win last time goes first;
  // a lone requester always wins.
  always_comb begin
    winner = OWNER_FETCH;
    if (reqs == 2'b11) begin
      if (last_owner == OWNER_FETCH) winner = OWNER_DATA;
      else                           winner = OWNER_FETCH;
    end else if (reqs[1]) begin
      winner = OWNER_DATA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single memory port between instruction fetch and the load/store
// path. One transaction is outstanding at a time: the winning request is
// registered onto mem_*, held until mem_gnt, then the response is routed back
// to its owner on mem_rvalid. A per-state wait counter aborts a stuck
// transaction with an error response.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   if_req/if_addr                   : fetch request
//   if_gnt/if_rvalid/if_err/if_stall : fetch handshake back to fetch stage
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata : load/store request
//   dm_gnt/dm_rvalid/dm_err/dm_stall : load/store handshake back
//   rdata                            : response data shared by both requesters
//   mem_req/we/be/addr/wdata         : registered request toward memory
//   mem_gnt/mem_rvalid/mem_rdata     : memory handshake and load data
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_WIDTH,
  parameter int DATA_W  = REG_DATA_WIDTH,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic              if_err,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic              dm_err,
  output logic              dm_stall,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  owner_e            pick;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic busy, timeout, gnt_fire, resp_fire, done, own_fetch;

  rr_pick2 u_pick (
    .reqs       ({dm_req, if_req}),
    .last_owner (last_owner_q),
    .winner     (pick)
  );

  // Event decode. The timeout takes priority over a grant or response that
  // arrives in the same cycle, so an aborted transaction never also completes.
  always_comb begin
    busy      = (state_q != ARB_IDLE);
    timeout   = busy && (cnt_q == CNT_W'(TIMEOUT));
    gnt_fire  = (state_q == ARB_WAIT_GNT) && mem_req_q && mem_gnt && !timeout;
    resp_fire = (state_q == ARB_WAIT_RESP) && mem_rvalid && !timeout;
    done      = resp_fire || timeout;
    own_fetch = (owner_q == OWNER_FETCH);
  end

  // Next-state, request capture and wait counter.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q + CNT_W'(1);
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (if_req || dm_req) begin
          state_d   = ARB_WAIT_GNT;
          owner_d   = pick;
          mem_req_d = 1'b1;
          if (pick == OWNER_DATA) begin
            mem_we_d    = dm_we;
            mem_be_d    = dm_be;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_be_d    = FETCH_BE;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      ARB_WAIT_GNT: begin
        if (timeout) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
        end else if (gnt_fire) begin
          state_d      = ARB_WAIT_RESP;
          mem_req_d    = 1'b0;
          last_owner_d = owner_q;
        end
      end
      ARB_WAIT_RESP: begin
        if (done) state_d = ARB_IDLE;
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // The counter measures time spent in the current state only.
    if (state_d != state_q || state_q == ARB_IDLE) cnt_d = '0;
  end

  // State and request registers; reset drops any transaction without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWNER_FETCH;
      last_owner_q <= OWNER_FETCH;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign if_gnt    = gnt_fire && own_fetch;
  assign dm_gnt    = gnt_fire && !own_fetch;
  assign if_rvalid = done && own_fetch;
  assign dm_rvalid = done && !own_fetch;
  assign if_err    = timeout && own_fetch;
  assign dm_err    = timeout && !own_fetch;
  assign rdata     = resp_fire ? mem_rdata : '0;

  // A requester stalls while its request is pending or its transaction is in
  // flight, and is released in the cycle its response is delivered.
  assign if_stall  = (if_req || (own_fetch && busy)) && !if_rvalid;
  assign dm_stall  = (dm_req || (!own_fetch && busy)) && !dm_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with a short timeout (4 cycles).
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled on the following falling edge.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [3:0]    dm_be;
  logic [DW-1:0] dm_wdata;
  logic          if_gnt, if_rvalid, if_err, if_stall;
  logic          dm_gnt, dm_rvalid, dm_err, dm_stall;
  logic [DW-1:0] rdata;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt, mem_rvalid;
  logic [DW-1:0] mem_rdata;

  logic [5:0]    flags;
  int            checks = 0;
  int            passes = 0;

  assign flags = {if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err};

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_err(if_err), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_err(dm_err),
    .dm_stall(dm_stall), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  // Advance to just after the next rising edge; memory strobes default low.
  task automatic step();
    @(posedge clk);
    #1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    if_req = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    sample();
    checks++; if (mem_req !== 1'b0) $display("[TB] FAIL reset_mem_req got %b want 0", mem_req); else passes++;
    checks++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== '0)
      $display("[TB] FAIL reset_mem_fields got we=%b be=%h addr=%h wdata=%h want 0", mem_we, mem_be, mem_addr, mem_wdata); else passes++;
    checks++; if (flags !== 6'b0) $display("[TB] FAIL reset_flags got %b want 000000", flags); else passes++;
    checks++; if ({if_stall, dm_stall} !== 2'b10) $display("[TB] FAIL reset_stalls got %b want 10", {if_stall, dm_stall}); else passes++;
    #1;
    rst = 1'b0;
    if_req = 1'b0;
  endtask

  task automatic test_fetch_only();
    do_reset();
    step(); if_req = 1'b1; if_addr = 32'h100; sample();
    checks++; if ({mem_req, if_stall} !== 2'b01) $display("[TB] FAIL fo_c0 got req/stall=%b want 01", {mem_req, if_stall}); else passes++;
    step(); mem_gnt = 1'b1; sample();
    checks++; if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100})
      $display("[TB] FAIL fo_mem_fields got req=%b we=%b be=%h addr=%h want 1 0 f 00000100", mem_req, mem_we, mem_be, mem_addr); else passes++;
    checks++; if (flags !== 6'b100000) $display("[TB] FAIL fo_gnt got %b want 100000", flags); else passes++;
    step(); if_req = 1'b0; sample();
    checks++; if ({mem_req, flags, if_stall} !== {1'b0, 6'b0, 1'b1})
      $display("[TB] FAIL fo_wait got req=%b flags=%b stall=%b want 0 000000 1", mem_req, flags, if_stall); else passes++;
    step(); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; sample();
    checks++; if ({flags, rdata} !== {6'b010000, 32'hDEAD_BEEF}) $display("[TB] FAIL fo_resp got flags=%b rdata=%h want 010000 deadbeef", flags, rdata); else passes++;
    checks++; if (if_stall !== 1'b0) $display("[TB] FAIL fo_stall_rel got %b want 0", if_stall); else passes++;
    step(); sample();
    checks++; if ({if_stall, flags} !== 7'b0) $display("[TB] FAIL fo_after got stall=%b flags=%b want 0", if_stall, flags); else passes++;
  endtask

  task automatic test_conflict();
    do_reset();
    step();
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0001; dm_addr = 32'h300; dm_wdata = 32'h55;
    sample();
    checks++; if ({if_stall, dm_stall} !== 2'b11) $display("[TB] FAIL cf_stalls got %b want 11", {if_stall, dm_stall}); else passes++;
    step(); mem_gnt = 1'b1; sample();
    checks++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'b0001, 32'h300, 32'h55})
      $display("[TB] FAIL cf_store_fields got we=%b be=%h addr=%h wdata=%h want 1 1 300 55", mem_we, mem_be, mem_addr, mem_wdata); else passes++;
    checks++; if (flags !== 6'b000100) $display("[TB] FAIL cf_dm_gnt got %b want 000100", flags); else passes++;
    step(); dm_req = 1'b0; sample();
    step(); mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; sample();
    checks++; if ({flags, dm_stall, if_stall} !== {6'b000010, 1'b0, 1'b1})
      $display("[TB] FAIL cf_dm_done got flags=%b dm_stall=%b if_stall=%b want 000010 0 1", flags, dm_stall, if_stall); else passes++;
    step(); sample();
    step(); mem_gnt = 1'b1; sample();
    checks++; if ({flags, mem_we, mem_be, mem_addr} !== {6'b100000, 1'b0, 4'hF, 32'h200})
      $display("[TB] FAIL cf_fetch got flags=%b we=%b be=%h addr=%h want 100000 0 f 200", flags, mem_we, mem_be, mem_addr); else passes++;
    step(); if_req = 1'b0; sample();
    step(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001; sample();
    checks++; if ({flags, rdata, if_stall} !== {6'b010000, 32'hCAFE_0001, 1'b0})
      $display("[TB] FAIL cf_if_done got flags=%b rdata=%h stall=%b want 010000 cafe0001 0", flags, rdata, if_stall); else passes++;
  endtask

  // Both requesters held high: owners must alternate at one transaction per 3 cycles.
  task automatic test_back_to_back();
    logic data_turn;
    logic [31:0] d;
    do_reset();
    data_turn = 1'b1;
    step();
    if_req = 1'b1; if_addr = 32'h400;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'b1100; dm_addr = 32'h500; dm_wdata = '0;
    sample();
    for (int k = 0; k < 4; k++) begin
      step(); mem_gnt = 1'b1; sample();
      checks++; if ({flags, mem_addr} !== (data_turn ? {6'b000100, 32'h500} : {6'b100000, 32'h400}))
        $display("[TB] FAIL b2b_gnt%0d got flags=%b addr=%h want data_turn=%b", k, flags, mem_addr, data_turn); else passes++;
      d = $urandom;
      step(); mem_rvalid = 1'b1; mem_rdata = d; sample();
      checks++; if ({flags, rdata} !== {(data_turn ? 6'b000010 : 6'b010000), d})
        $display("[TB] FAIL b2b_resp%0d got flags=%b rdata=%h want data_turn=%b rdata=%h", k, flags, rdata, data_turn, d); else passes++;
      step(); sample();
      checks++; if ({mem_req, flags} !== 7'b0) $display("[TB] FAIL b2b_idle%0d got req=%b flags=%b want 0", k, mem_req, flags); else passes++;
      data_turn = ~data_turn;
    end
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    step(); if_req = 1'b1; if_addr = 32'h600; mem_rdata = 32'hFFFF_FFFF; sample();
    for (int i = 0; i < TO; i++) begin
      step(); mem_rdata = 32'hFFFF_FFFF; sample();
      checks++; if ({mem_req, flags} !== {1'b1, 6'b0}) $display("[TB] FAIL to_gnt_wait%0d got req=%b flags=%b want 1 000000", i, mem_req, flags); else passes++;
    end
    step(); mem_rdata = 32'hFFFF_FFFF; sample();
    checks++; if ({flags, rdata, if_stall} !== {6'b011000, 32'h0, 1'b0})
      $display("[TB] FAIL to_gnt_abort got flags=%b rdata=%h stall=%b want 011000 0 0", flags, rdata, if_stall); else passes++;
    if_req = 1'b0;
    step(); mem_rvalid = 1'b1; sample();
    checks++; if ({mem_req, flags} !== 7'b0) $display("[TB] FAIL to_late_rvalid got req=%b flags=%b want 0", mem_req, flags); else passes++;
    // Timeout while waiting for the response of a granted load.
    step(); dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h640; sample();
    step(); mem_gnt = 1'b1; sample();
    checks++; if (flags !== 6'b000100) $display("[TB] FAIL to_resp_gnt got %b want 000100", flags); else passes++;
    for (int i = 0; i < TO; i++) begin
      step(); dm_req = 1'b0; sample();
      checks++; if ({flags, dm_stall} !== {6'b0, 1'b1}) $display("[TB] FAIL to_resp_wait%0d got flags=%b stall=%b want 0 1", i, flags, dm_stall); else passes++;
    end
    step(); sample();
    checks++; if ({flags, rdata} !== {6'b000011, 32'h0}) $display("[TB] FAIL to_resp_abort got flags=%b rdata=%h want 000011 0", flags, rdata); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(); if_req = 1'b1; if_addr = 32'h900; sample();
    step(); mem_gnt = 1'b1; sample();
    step(); if_req = 1'b0; rst = 1'b1; sample();
    step(); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777; sample();
    checks++; if ({flags, if_stall, dm_stall} !== 8'b0) $display("[TB] FAIL rm_no_resp got flags=%b stalls=%b want 0", flags, {if_stall, dm_stall}); else passes++;
    checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== '0)
      $display("[TB] FAIL rm_fields got req=%b addr=%h be=%h want 0", mem_req, mem_addr, mem_be); else passes++;
    step(); dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0110; dm_addr = 32'hA00; dm_wdata = 32'hABCD; sample();
    step(); mem_gnt = 1'b1; sample();
    checks++; if ({flags, mem_addr, mem_wdata} !== {6'b000100, 32'hA00, 32'hABCD})
      $display("[TB] FAIL rm_after_gnt got flags=%b addr=%h wdata=%h want 000100 a00 abcd", flags, mem_addr, mem_wdata); else passes++;
    step(); dm_req = 1'b0; sample();
    step(); mem_rvalid = 1'b1; sample();
    checks++; if (flags !== 6'b000010) $display("[TB] FAIL rm_after_resp got %b want 000010", flags); else passes++;
  endtask

  // The data requester drops its request before the grant; the captured
  // transaction still completes.
  task automatic test_protocol_drop();
    do_reset();
    step(); dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h700; sample();
    step(); dm_req = 1'b0; sample();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h700}) $display("[TB] FAIL pd_held got req=%b addr=%h want 1 700", mem_req, mem_addr); else passes++;
    step(); mem_gnt = 1'b1; sample();
    step(); sample();
    step(); mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D; sample();
    checks++; if ({flags, rdata} !== {6'b000010, 32'h0BAD_F00D})
      $display("[TB] FAIL pd_resp got flags=%b rdata=%h want 000010 0badf00d", flags, rdata); else passes++;
  endtask

  // Random request streams with random memory latencies, checked against a
  // transaction-level model: lone requester wins, conflicts alternate starting
  // with data after reset, and every response goes back to the winner.
  task automatic test_random();
    logic        if_pend, dm_pend, last_data, win_data;
    logic [31:0] if_a, d_a, d_wd, exp_addr, exp_wd, d;
    logic        d_we, exp_we;
    logic [3:0]  d_be, exp_be;
    int          gd, rd;
    do_reset();
    if_pend = 1'b0; dm_pend = 1'b0; last_data = 1'b0;
    if_a = '0; d_a = '0; d_wd = '0; d_we = 1'b0; d_be = '0;
    for (int t = 0; t < 40; t++) begin
      if (!if_pend && ($urandom_range(2) != 0)) begin
        if_pend = 1'b1; if_a = $urandom;
      end
      if (!dm_pend && ($urandom_range(2) != 0)) begin
        dm_pend = 1'b1; d_a = $urandom; d_wd = $urandom;
        d_we = 1'($urandom_range(1)); d_be = 4'($urandom_range(15));
      end
      step();
      if_req = if_pend; if_addr = if_a;
      dm_req = dm_pend; dm_addr = d_a; dm_wdata = d_wd; dm_we = d_we; dm_be = d_be;
      sample();
      checks++; if ({mem_req, flags, if_stall, dm_stall} !== {1'b0, 6'b0, if_pend, dm_pend})
        $display("[TB] FAIL rnd_arb%0d got req=%b flags=%b stalls=%b want 0 0 %b%b", t, mem_req, flags, {if_stall, dm_stall}, if_pend, dm_pend); else passes++;
      if (if_pend || dm_pend) begin
        win_data = (if_pend && dm_pend) ? !last_data : dm_pend;
        exp_addr = win_data ? d_a  : if_a;
        exp_we   = win_data ? d_we : 1'b0;
        exp_be   = win_data ? d_be : 4'hF;
        exp_wd   = d_wd;
        gd = $urandom_range(2);
        for (int i = 0; i < gd; i++) begin
          step(); mem_rvalid = 1'($urandom_range(1)); sample();
          checks++; if ({mem_req, flags, mem_addr} !== {1'b1, 6'b0, exp_addr})
            $display("[TB] FAIL rnd_gwait%0d got req=%b flags=%b addr=%h want 1 0 %h", t, mem_req, flags, mem_addr, exp_addr); else passes++;
        end
        step(); mem_gnt = 1'b1; sample();
        checks++; if ({flags, mem_addr, mem_we, mem_be} !== {(win_data ? 6'b000100 : 6'b100000), exp_addr, exp_we, exp_be})
          $display("[TB] FAIL rnd_gnt%0d got flags=%b addr=%h we=%b be=%h want data=%b addr=%h we=%b be=%h",
                   t, flags, mem_addr, mem_we, mem_be, win_data, exp_addr, exp_we, exp_be); else passes++;
        if (win_data) begin
          checks++; if (mem_wdata !== exp_wd) $display("[TB] FAIL rnd_wdata%0d got %h want %h", t, mem_wdata, exp_wd); else passes++;
          dm_pend = 1'b0;
        end else begin
          if_pend = 1'b0;
        end
        last_data = win_data;
        rd = $urandom_range(2);
        for (int i = 0; i < rd; i++) begin
          step(); if_req = if_pend; dm_req = dm_pend; sample();
          checks++; if ({mem_req, flags, (win_data ? dm_stall : if_stall)} !== {1'b0, 6'b0, 1'b1})
            $display("[TB] FAIL rnd_rwait%0d got req=%b flags=%b want 0 0 stall=1", t, mem_req, flags); else passes++;
        end
        d = $urandom;
        step(); if_req = if_pend; dm_req = dm_pend; mem_rvalid = 1'b1; mem_rdata = d; sample();
        checks++; if ({flags, rdata, (win_data ? dm_stall : if_stall)} !== {(win_data ? 6'b000010 : 6'b010000), d, 1'b0})
          $display("[TB] FAIL rnd_resp%0d got flags=%b rdata=%h want data=%b rdata=%h", t, flags, rdata, win_data, d); else passes++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_conflict();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_protocol_drop();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between instruction fetch and the execution unit's load/store path (von Neumann memory, one bus). It arbitrates between the two requesters and captures the winning request. It drives a req/gnt/rvalid handshake toward memory with at most one transaction outstanding, and routes the response back to its owner. It sits between the fetch stage and `executionUnit` on one side and the memory interface on the other; while a requester waits, its stall output is held high.

## Interface
- `ADDR_W`, default `MEM_ADDR_WIDTH` (32): address width.
- `DATA_W`, default `REG_DATA_WIDTH` (32): data width.
- `TIMEOUT`, default 16: maximum cycles in WAIT_GNT or WAIT_RESP before abort, ≥2.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request; held until `if_gnt`.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch request accepted by memory.
- `if_rvalid` out 1: fetch response valid, one-cycle pulse.
- `if_err` out 1: fetch aborted by timeout; qualifies `if_rvalid`.
- `if_stall` out 1: fetch request pending and not yet answered.
- `dm_req` in 1: data request; held until `dm_gnt`.
- `dm_we` in 1: 1 = store.
- `dm_be` in 4: byte enables.
- `dm_addr` in ADDR_W: data address (from `addr_mem_data_o`).
- `dm_wdata` in DATA_W: store data (from `val_mem_data_write_o`).
- `dm_gnt`, `dm_rvalid`, `dm_err`, `dm_stall` out 1: same meaning as the fetch equivalents.
- `rdata` out DATA_W: response data, shared by both requesters; valid with either rvalid.
- `mem_req` out 1: request to memory (registered).
- `mem_we` out 1, `mem_be` out 4, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: registered request fields.
- `mem_gnt` in 1: memory accepts the request.
- `mem_rvalid` in 1: memory response (loads and stores).
- `mem_rdata` in DATA_W: load data.

## Operation
- States: IDLE, WAIT_GNT, WAIT_RESP.
- IDLE: if any request is pending, pick a winner, register the owner, fields and `mem_req`=1, then go to WAIT_GNT.
- Fetch requests register `we`=0 and `be`=4'hF.
- Conflict (both requesting): round-robin. The requester that was not `last_owner` wins. `last_owner` updates on every grant.
- Single requester: it wins.
- WAIT_GNT: `mem_req` held with stable fields. On `mem_gnt`, the owner's gnt = 1 in that cycle (combinational, `mem_gnt & mem_req & owner`), `mem_req` deasserts next cycle, go to WAIT_RESP.
- WAIT_RESP: on `mem_rvalid`, pulse the owner's rvalid and set `rdata` = `mem_rdata` combinationally, then go to IDLE. Stores also complete on `mem_rvalid`, and `rdata` is don't-care for them.
- `mem_rvalid` in IDLE or WAIT_GNT is ignored.
- Timeout: a wait counter clears on each state entry. If it reaches TIMEOUT in WAIT_GNT or WAIT_RESP:
  - pulse the owner's rvalid with err=1 and `rdata`=0;
  - drop `mem_req`;
  - go to IDLE.
  - A late `mem_rvalid` after abort is ignored.
- Stall: `x_stall = x_req | (owner==x & state!=IDLE)`, cleared in the cycle the owner's rvalid pulses.
- A requester that drops req before gnt is a protocol violation. The captured transaction still completes and its response is still delivered.
- `mem_gnt` while `mem_req`=0 is ignored.

## Timing
- Reset values:
  - state IDLE, counter 0, `last_owner`=FETCH, so data wins the first conflict;
  - `mem_req`=0 and all `mem_*` fields 0;
  - all gnt/rvalid/err = 0;
  - stalls follow their requests combinationally.
- Reset mid-transaction aborts silently: no rvalid is generated, and a later `mem_rvalid` is ignored.
- Latency:
  - request seen in cycle N gives `mem_req` high in cycle N+1;
  - with `mem_gnt` in N+1, `mem_rvalid` is earliest at N+2;
  - the owner's rvalid is in the same cycle as `mem_rvalid`;
  - re-arbitration happens in the next cycle, so back-to-back throughput is one transaction per 3 cycles minimum.
- Memory must not assert `mem_rvalid` in the same cycle as `mem_gnt`.
- Timeout abort fires in the cycle where the counter equals TIMEOUT, i.e. TIMEOUT cycles after state entry.

## Structure
- The shared package/defines header (`src/defines.vh`) carries:
  - owner encodings `OWNER_FETCH`/`OWNER_DATA`;
  - state encodings `ARB_IDLE`/`ARB_WAIT_GNT`/`ARB_WAIT_RESP`;
  - `ARB_TIMEOUT_DEFAULT`.
- One natural sub-module: `rr_pick2`, a two-requester round-robin picker (inputs: reqs, last_owner; output: winner). It is combinational; the FSM, registers and counter live in the top.

## Test plan
- Fetch only: `if_addr`=0x100, `mem_gnt` in cycle 1, `mem_rvalid` with 0xDEADBEEF in cycle 3. Expect `mem_addr`=0x100, `mem_be`=F, `if_gnt` in cycle 1, `if_rvalid` and `rdata`=0xDEADBEEF in cycle 3, `if_stall` low afterwards.
- Simultaneous requests after reset, with fetch at 0x200 and store 0x55 to 0x300 with be=0001. Expect data served first (`mem_we`=1, `mem_wdata`=0x55), then fetch, and `dm_stall`/`if_stall` released in that order.
- Both requesters held continuously for 4 transactions. Expect owners alternate data, fetch, data, fetch.
- `mem_gnt` held low with TIMEOUT=4. Expect the owner's rvalid=1 with err=1 and `rdata`=0 exactly 4 cycles after WAIT_GNT entry, `mem_req` low next cycle, and a late `mem_rvalid` ignored.
- Assert `rst` during WAIT_RESP, then send `mem_rvalid`. Expect no rvalid to either requester, all outputs at reset values, and normal operation on the next request.
